// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control slice: controller state encodings
// and register-address constants used by ID, EX and the register bank.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection with the ID stall and IF/ID flush
// strobes, gated by the controller's enable and halt.
module hazard_detect #(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  i_enable,
  input  logic                  i_halt,
  input  logic                  i_jump_id,
  input  logic                  i_mem_read_ex,
  input  logic [REG_ADDR_W-1:0] i_rt_ex,
  input  logic [REG_ADDR_W-1:0] i_rs_id,
  input  logic [REG_ADDR_W-1:0] i_rt_id,
  output logic                  o_lu,
  output logic                  o_stall,
  output logic                  o_flush_if
);
  import pipeline_pkg::*;

  always_comb begin
    o_lu       = i_mem_read_ex && (i_rt_ex != REG_ADDR_W'(REG_ZERO)) &&
                 ((i_rt_ex == i_rs_id) || (i_rt_ex == i_rt_id));
    // A jump waiting on a stalled operand is flushed only once the stall clears.
    o_stall    = i_enable && o_lu && !i_halt;
    o_flush_if = i_enable && i_jump_id && !o_lu && !i_halt;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Run/step sequencing, HALT drain and cycle counting for the five-stage pipeline;
// hazard strobes come from hazard_detect.
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_clear,
  input  logic                  i_halt_id,
  input  logic                  i_jump_id,
  input  logic                  i_mem_read_ex,
  input  logic [REG_ADDR_W-1:0] i_rt_ex,
  input  logic [REG_ADDR_W-1:0] i_rs_id,
  input  logic [REG_ADDR_W-1:0] i_rt_id,
  output logic                  o_enable,
  output logic                  o_stall,
  output logic                  o_flush_if,
  output logic                  o_halt,
  output logic [2:0]            o_state,
  output logic [CNT_W-1:0]      o_cycle_count,
  output logic                  o_step_done,
  output logic                  o_done
);
  import pipeline_pkg::*;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t         state, state_next;
  logic [DCW-1:0] drain_cnt;
  logic           lu, halt_acc, step_done_next, done_next;

  always_comb begin
    o_enable = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
    o_halt   = (state == ST_DRAIN) || (state == ST_HALTED);
    o_state  = state;
  end

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .i_enable      (o_enable),
    .i_halt        (o_halt),
    .i_jump_id     (i_jump_id),
    .i_mem_read_ex (i_mem_read_ex),
    .i_rt_ex       (i_rt_ex),
    .i_rs_id       (i_rs_id),
    .i_rt_id       (i_rt_id),
    .o_lu          (lu),
    .o_stall       (o_stall),
    .o_flush_if    (o_flush_if)
  );

  // Enabled and not already halting means RUN or STEP.
  assign halt_acc = i_halt_id && o_enable && !o_halt && !lu;

  always_comb begin
    state_next     = state;
    step_done_next = 1'b0;
    done_next      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_run)       state_next = ST_RUN;
        else if (i_step) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_acc) state_next = ST_DRAIN;
      end
      ST_STEP: begin
        if (halt_acc) begin
          state_next = ST_DRAIN;
        end else begin
          state_next     = ST_IDLE;
          step_done_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = ST_HALTED;
          done_next  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (i_clear) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      o_step_done <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_next;
      o_step_done <= step_done_next;
      o_done      <= done_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      drain_cnt <= '0;
    end else if (state != ST_DRAIN && state_next == ST_DRAIN) begin
      drain_cnt <= DCW'(DRAIN_CYCLES - 1);
    end else if (state == ST_DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - DCW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)      o_cycle_count <= '0;
    else if (i_clear)  o_cycle_count <= '0;
    else if (o_enable) o_cycle_count <= o_cycle_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus randomized
// traffic checked against a behavioural model of the controller.
module tb_pipeline_controller;
  localparam int DRAIN = 4;
  localparam int RW    = 5;
  localparam int CW    = 32;

  logic          i_clk = 1'b0;
  logic          i_reset, i_run, i_step, i_clear, i_halt_id, i_jump_id, i_mem_read_ex;
  logic [RW-1:0] i_rt_ex, i_rs_id, i_rt_id;
  logic          o_enable, o_stall, o_flush_if, o_halt, o_step_done, o_done;
  logic [2:0]    o_state;
  logic [CW-1:0] o_cycle_count;

  int checks = 0;
  int errors = 0;

  pipeline_controller #(.DRAIN_CYCLES(DRAIN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step), .i_clear(i_clear),
    .i_halt_id(i_halt_id), .i_jump_id(i_jump_id), .i_mem_read_ex(i_mem_read_ex),
    .i_rt_ex(i_rt_ex), .i_rs_id(i_rs_id), .i_rt_id(i_rt_id),
    .o_enable(o_enable), .o_stall(o_stall), .o_flush_if(o_flush_if), .o_halt(o_halt),
    .o_state(o_state), .o_cycle_count(o_cycle_count), .o_step_done(o_step_done), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural reference: mode plus the edge at which a drain must end.
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mmode_t;
  mmode_t        m_mode;
  int unsigned   m_cyc, m_end;
  logic [CW-1:0] m_count;
  logic          m_sd, m_done;

  function automatic logic f_lu();
    return i_mem_read_ex && (i_rt_ex != 0) && (i_rt_ex == i_rs_id || i_rt_ex == i_rt_id);
  endfunction
  function automatic logic f_en();
    return (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
  endfunction
  function automatic logic f_halt();
    return (m_mode == M_DRAIN) || (m_mode == M_HALTED);
  endfunction
  function automatic logic [2:0] f_state();
    case (m_mode)
      M_RUN:    return pipeline_pkg::ST_RUN;
      M_STEP:   return pipeline_pkg::ST_STEP;
      M_DRAIN:  return pipeline_pkg::ST_DRAIN;
      M_HALTED: return pipeline_pkg::ST_HALTED;
      default:  return pipeline_pkg::ST_IDLE;
    endcase
  endfunction

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_mode <= M_IDLE; m_cyc <= 0; m_end <= 0; m_count <= '0; m_sd <= 1'b0; m_done <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_sd   <= 1'b0;
      m_done <= 1'b0;
      if (i_clear)     m_count <= '0;
      else if (f_en()) m_count <= m_count + 1;
      case (m_mode)
        M_IDLE: if (i_run) m_mode <= M_RUN; else if (i_step) m_mode <= M_STEP;
        M_RUN, M_STEP:
          if (i_halt_id && !f_lu()) begin
            m_mode <= M_DRAIN;
            m_end  <= m_cyc + DRAIN;
          end else if (m_mode == M_STEP) begin
            m_mode <= M_IDLE;
            m_sd   <= 1'b1;
          end
        M_DRAIN:  if (m_cyc == m_end) begin m_mode <= M_HALTED; m_done <= 1'b1; end
        M_HALTED: if (i_clear) m_mode <= M_IDLE;
        default:  m_mode <= M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic quiet();
    i_run = 0; i_step = 0; i_clear = 0; i_halt_id = 0; i_jump_id = 0;
    i_mem_read_ex = 0; i_rt_ex = '0; i_rs_id = '0; i_rt_id = '0;
  endtask

  task automatic test_reset();
    quiet();
    i_reset = 0;
    i_mem_read_ex = 1; i_rt_ex = 3; i_rs_id = 3; i_jump_id = 1;
    tick(); tick();
    checks++;
    if ({o_state, o_enable, o_halt, o_step_done, o_done, o_stall, o_flush_if} !== {3'(pipeline_pkg::ST_IDLE), 6'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {o_state, o_enable, o_halt, o_step_done, o_done, o_stall, o_flush_if}, {3'(pipeline_pkg::ST_IDLE), 6'b0});
    end
    checks++;
    if (o_cycle_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", o_cycle_count);
    end
    quiet();
    @(negedge i_clk) i_reset = 1;
    tick();
  endtask

  task automatic test_step();
    int en_cnt = 0, sd_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      i_step = 1; tick(); i_step = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge i_clk);
        if (o_enable)    en_cnt++;
        if (o_step_done) sd_cnt++;
        tick();
      end
    end
    checks++;
    if (en_cnt !== 3) begin errors++; $display("FAIL step_enables: got %0d expected 3", en_cnt); end
    checks++;
    if (sd_cnt !== 3) begin errors++; $display("FAIL step_done_pulses: got %0d expected 3", sd_cnt); end
    checks++;
    if (o_cycle_count !== 3) begin errors++; $display("FAIL step_count: got %0d expected 3", o_cycle_count); end
  endtask

  task automatic test_load_use();
    logic exp_stall, exp_flush;
    i_run = 1; tick(); i_run = 0;
    i_mem_read_ex = 1; i_rt_ex = 2; i_rs_id = 2; i_rt_id = 7;
    @(negedge i_clk);
    checks++;
    if (o_stall !== 1'b1) begin errors++; $display("FAIL lw_stall: got %b expected 1", o_stall); end
    i_rt_ex = 0; i_rs_id = 0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("FAIL lw_r0_stall: got %b expected 0", o_stall); end
    tick();
    for (int c = 0; c < 40; c++) begin
      i_mem_read_ex = 1'($urandom_range(1)); i_jump_id = 1'($urandom_range(1));
      i_rt_ex = RW'($urandom_range(3)); i_rs_id = RW'($urandom_range(3)); i_rt_id = RW'($urandom_range(3));
      @(negedge i_clk);
      exp_stall = f_en() && f_lu() && !f_halt();
      exp_flush = f_en() && i_jump_id && !f_lu() && !f_halt();
      checks++;
      if ({o_stall, o_flush_if} !== {exp_stall, exp_flush}) begin
        errors++; $display("FAIL hazard_rand: got %b expected %b", {o_stall, o_flush_if}, {exp_stall, exp_flush});
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_jump();
    i_jump_id = 1;
    @(negedge i_clk);
    checks++;
    if ({o_flush_if, o_stall} !== 2'b10) begin errors++; $display("FAIL jump_flush: got %b expected 10", {o_flush_if, o_stall}); end
    tick(); i_jump_id = 0;
    @(negedge i_clk);
    checks++;
    if (o_flush_if !== 1'b0) begin errors++; $display("FAIL jump_one_cycle: got %b expected 0", o_flush_if); end
    i_jump_id = 1; i_mem_read_ex = 1; i_rt_ex = 4; i_rt_id = 4;
    #1;
    checks++;
    if ({o_flush_if, o_stall} !== 2'b01) begin errors++; $display("FAIL jump_hazard: got %b expected 01", {o_flush_if, o_stall}); end
    tick(); quiet();
  endtask

  task automatic test_halt();
    logic [CW-1:0] frozen;
    logic [CW-1:0] exp_cnt;
    i_halt_id = 1; i_mem_read_ex = 1; i_rt_ex = 5; i_rs_id = 5;
    tick();
    checks++;
    if (o_state !== 3'(pipeline_pkg::ST_RUN)) begin errors++; $display("FAIL halt_vs_stall: got %0d expected %0d", o_state, pipeline_pkg::ST_RUN); end
    i_mem_read_ex = 0;
    exp_cnt = m_count + DRAIN + 1;
    tick();
    i_halt_id = 0;
    for (int k = 1; k <= DRAIN; k++) begin
      @(negedge i_clk);
      checks++;
      if ({o_halt, o_enable, o_done, o_state} !== {3'b110, 3'(pipeline_pkg::ST_DRAIN)}) begin
        errors++; $display("FAIL drain_cycle%0d: got %b expected %b", k, {o_halt, o_enable, o_done, o_state}, {3'b110, 3'(pipeline_pkg::ST_DRAIN)});
      end
      tick();
    end
    @(negedge i_clk);
    checks++;
    if ({o_done, o_halt, o_enable, o_state} !== {3'b110, 3'(pipeline_pkg::ST_HALTED)}) begin
      errors++; $display("FAIL halted_done: got %b expected %b", {o_done, o_halt, o_enable, o_state}, {3'b110, 3'(pipeline_pkg::ST_HALTED)});
    end
    checks++;
    if (o_cycle_count !== exp_cnt) begin errors++; $display("FAIL halt_count: got %0d expected %0d", o_cycle_count, exp_cnt); end
    frozen = exp_cnt;
    tick(); tick(); tick();
    checks++;
    if ({o_cycle_count, o_done} !== {frozen, 1'b0}) begin
      errors++; $display("FAIL halted_frozen: got %0d/%b expected %0d/0", o_cycle_count, o_done, frozen);
    end
    i_clear = 1; tick(); i_clear = 0;
    checks++;
    if ({o_state, o_cycle_count} !== {3'(pipeline_pkg::ST_IDLE), CW'(0)}) begin
      errors++; $display("FAIL clear_halted: got %0d/%0d expected %0d/0", o_state, o_cycle_count, pipeline_pkg::ST_IDLE);
    end
  endtask

  task automatic test_run_step_together();
    int sd_cnt = 0;
    i_run = 1; i_step = 1; tick(); i_run = 0; i_step = 0;
    checks++;
    if (o_state !== 3'(pipeline_pkg::ST_RUN)) begin errors++; $display("FAIL run_wins: got %0d expected %0d", o_state, pipeline_pkg::ST_RUN); end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      if (o_step_done) sd_cnt++;
      tick();
    end
    checks++;
    if (sd_cnt !== 0) begin errors++; $display("FAIL run_no_step_done: got %0d expected 0", sd_cnt); end
    i_clear = 1; tick(); i_clear = 0;
    checks++;
    if ({o_state, o_cycle_count} !== {3'(pipeline_pkg::ST_RUN), CW'(0)}) begin
      errors++; $display("FAIL clear_in_run: got %0d/%0d expected %0d/0", o_state, o_cycle_count, pipeline_pkg::ST_RUN);
    end
  endtask

  task automatic test_reset_mid_drain();
    int done_cnt = 0;
    i_halt_id = 1; tick(); i_halt_id = 0;
    tick();
    #2 i_reset = 0;
    #1;
    checks++;
    if ({o_state, o_cycle_count, o_halt, o_done} !== {3'(pipeline_pkg::ST_IDLE), CW'(0), 2'b00}) begin
      errors++; $display("FAIL reset_mid_drain: got %0d/%0d/%b/%b expected %0d/0/0/0",
                         o_state, o_cycle_count, o_halt, o_done, pipeline_pkg::ST_IDLE);
    end
    @(negedge i_clk) i_reset = 1;
    for (int c = 0; c < DRAIN + 2; c++) begin
      @(negedge i_clk);
      if (o_done) done_cnt++;
    end
    checks++;
    if ({done_cnt, o_state} !== {32'd0, 3'(pipeline_pkg::ST_IDLE)}) begin
      errors++; $display("FAIL no_done_after_reset: got %0d/%0d expected 0/%0d", done_cnt, o_state, pipeline_pkg::ST_IDLE);
    end
    tick();
  endtask

  task automatic test_random();
    logic [14:0] got, exp;
    for (int c = 0; c < 400; c++) begin
      i_run = ($urandom_range(7) == 0); i_step = ($urandom_range(5) == 0);
      i_clear = ($urandom_range(19) == 0); i_halt_id = ($urandom_range(9) == 0);
      i_jump_id = 1'($urandom_range(1)); i_mem_read_ex = 1'($urandom_range(1));
      i_rt_ex = RW'($urandom_range(3)); i_rs_id = RW'($urandom_range(3)); i_rt_id = RW'($urandom_range(3));
      @(negedge i_clk);
      got = {o_state, o_enable, o_halt, o_step_done, o_done, o_stall, o_flush_if, o_cycle_count[5:0]};
      exp = {f_state(), f_en(), f_halt(), m_sd, m_done, f_en() && f_lu() && !f_halt(),
             f_en() && i_jump_id && !f_lu() && !f_halt(), m_count[5:0]};
      checks++;
      if (got !== exp || o_cycle_count !== m_count) begin
        errors++; $display("FAIL random_c%0d: got %b/%0d expected %b/%0d", c, got, o_cycle_count, exp, m_count);
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_step();
    test_load_use();
    test_jump();
    test_halt();
    test_run_step_together();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Sequencing and hazard controller for the five-stage MIPS pipeline. Gates the global stage-advance enable for run and single-step modes. Detects load-use hazards between EX and ID and drives the `i_stall` input of the instruction-decode stage. Flushes IF/ID on taken jumps, and drains the pipeline after a HALT reaches ID before reporting completion. Sits beside the datapath, between the debug/host interface and the IF, ID, EX, MEM and WB stage registers.

## Interface
Parameters:
- `DRAIN_CYCLES`, 4: enabled cycles after HALT leaves ID until its WB completes.
- `REG_ADDR_W`, 5: register address width.
- `CNT_W`, 32: cycle-counter width.

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_run`, in, 1: one-cycle pulse that starts continuous execution.
- `i_step`, in, 1: one-cycle pulse that advances the pipeline exactly one cycle.
- `i_clear`, in, 1: one-cycle pulse, HALTED→IDLE, clears counter.
- `i_halt_id`, in, 1: HALT decoded in ID (ID `o_halt`).
- `i_jump_id`, in, 1: jump taken in ID (ID `o_jump`).
- `i_mem_read_ex`, in, 1: ID/EX register holds a load.
- `i_rt_ex`, in, REG_ADDR_W: load destination in EX.
- `i_rs_id`, in, REG_ADDR_W: source rs in ID.
- `i_rt_id`, in, REG_ADDR_W: source rt in ID.
- `o_enable`, out, 1: all stage registers and the PC advance when high.
- `o_stall`, out, 1: hold PC and IF/ID, insert bubble into ID/EX.
- `o_flush_if`, out, 1: replace IF/ID contents with NOP.
- `o_halt`, out, 1: drives ID `i_halt`; stops fetch, forces bubbles.
- `o_state`, out, 3: current FSM state encoding.
- `o_cycle_count`, out, CNT_W: number of enabled cycles.
- `o_step_done`, out, 1: one-cycle pulse after a step cycle.
- `o_done`, out, 1: one-cycle pulse on entry to HALTED.

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED.
  - IDLE: `o_enable`=0. `i_run`→RUN; otherwise `i_step`→STEP. If both are asserted, RUN wins.
  - RUN: `o_enable`=1. An accepted halt→DRAIN. `i_run` and `i_step` are ignored.
  - STEP: `o_enable`=1 for exactly one cycle. Next state is IDLE with `o_step_done`=1 that cycle, or DRAIN if the halt is accepted.
  - DRAIN: `o_enable`=1 and `o_halt`=1. The drain counter loads `DRAIN_CYCLES-1` on entry and decrements each cycle. At 0→HALTED with `o_done` pulse. Drain runs freely even when entered from STEP.
  - HALTED: `o_enable`=0, `o_halt`=1. Only `i_clear` exits, to IDLE.
- Load-use hazard: `lu = i_mem_read_ex & (i_rt_ex!=0) & (i_rt_ex==i_rs_id | i_rt_ex==i_rt_id)`.
- `o_stall = o_enable & lu & ~o_halt`.
- `o_flush_if = o_enable & i_jump_id & ~lu & ~o_halt`. A jump whose operands are stalled waits one cycle.
- Halt accepted when `i_halt_id & o_enable & ~lu`. A stall takes priority and the halt is re-evaluated next cycle.
- `o_cycle_count` increments on every cycle with `o_enable`=1, including stall and drain cycles. It wraps modulo 2^CNT_W and clears on `i_clear`.
- `i_clear` outside HALTED clears the counter only; the state is unchanged.

## Timing
- Reset values (asynchronous assert, synchronous release): state IDLE, `o_enable`=0, `o_halt`=0, `o_cycle_count`=0, pulses 0. `o_stall` and `o_flush_if` are 0 as a consequence.
- Outputs `o_enable`, `o_halt`, `o_state`, `o_cycle_count`, `o_step_done` and `o_done` are registered or pure state decode.
- Outputs `o_stall` and `o_flush_if` are combinational from inputs gated by state. They are valid in the same cycle the ID and EX values are valid.
- `i_run` or `i_step` sampled at edge N gives `o_enable`=1 in cycle N+1.
- HALT accepted at edge N: DRAIN occupies cycles N+1 through N+DRAIN_CYCLES, and `o_done` and HALTED are in cycle N+DRAIN_CYCLES+1.
- Reset mid-operation aborts immediately, including mid-DRAIN, with no `o_done`.

## Structure
- Shared package `pipeline_pkg`:
  - state enum encodings;
  - `REG_ZERO` constant;
  - `REG_ADDR_W`, which is shared with ID, EX and the register bank.
- One natural sub-module, `hazard_detect`: the combinational `lu`, `o_stall` and `o_flush_if` logic. The FSM, drain counter and cycle counter stay in the top.

## Test plan
- Reset, then `i_step` pulse three times with gaps → exactly three cycles with `o_enable`=1, three `o_step_done` pulses, `o_cycle_count`=3.
- RUN with EX `LW $2,4($1)` (`i_mem_read_ex`=1, `i_rt_ex`=2) and ID `i_rs_id`=2 → `o_stall`=1 for that cycle. With `i_rt_ex`=0 → `o_stall`=0.
- RUN, `i_jump_id`=1 with no hazard → `o_flush_if`=1 for one cycle. Jump together with a hazard → `o_flush_if`=0 and `o_stall`=1.
- RUN, `i_halt_id` at edge N → `o_halt`=1 from N+1, `o_done` at N+5 (DRAIN_CYCLES=4), state HALTED, counter frozen. `i_clear` → IDLE, counter 0.
- `i_run` and `i_step` asserted together in IDLE → RUN, no `o_step_done`. Assert `i_reset` low mid-DRAIN → IDLE and counter 0 at once, no `o_done`.
